// File: rtl/omp_pkg.sv
// Constants and types shared by the frame packer and the OPBOMP detector.
// The detector benches import the same package so frame geometry stays in one place.
`timescale 1ns/1ps
package omp_pkg;

  localparam int N_SAMPLES = 24;
  localparam int SAMPLE_W  = 16;
  localparam int X_W       = N_SAMPLES * SAMPLE_W;
  localparam int POS_W     = 6;
  localparam int CNT_W     = 5;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Slot 0 occupies the most significant sample position of the flat vector.
  function automatic int slot_lsb(input int k);
    return (N_SAMPLES - 1 - k) * SAMPLE_W;
  endfunction

endpackage

// File: rtl/omp_frame_packer_if.sv
// Sample stream in and packed frame out of the OPBOMP front end.
// master = sample source / frame consumer side, slave = the packer.
`timescale 1ns/1ps
interface omp_frame_packer_if;
  import omp_pkg::*;

  logic                 s_valid;
  logic                 s_ready;
  sample_t              s_data;
  logic                 s_last;
  logic                 frame_valid;
  logic                 frame_ready;
  logic [X_W-1:0]       x_vec;
  logic [CNT_W-1:0]     frame_len;
  logic                 short_frame;

  modport master (
    output s_valid, s_data, s_last, frame_ready,
    input  s_ready, frame_valid, x_vec, frame_len, short_frame
  );

  modport slave (
    input  s_valid, s_data, s_last, frame_ready,
    output s_ready, frame_valid, x_vec, frame_len, short_frame
  );

endinterface

// File: rtl/omp_slot_decoder.sv
// Turns the slot counter into a one-hot write enable and a mask of the
// slots above it, which get zeroed when a frame closes early.
`timescale 1ns/1ps
module omp_slot_decoder
  import omp_pkg::*;
(
  input  logic [CNT_W-1:0]     slot,
  output logic [N_SAMPLES-1:0] slot_we,
  output logic [N_SAMPLES-1:0] tail_mask
);

  generate
    for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_slot
      assign slot_we[gi]   = (slot == CNT_W'(gi));
      assign tail_mask[gi] = (CNT_W'(gi) > slot);
    end
  endgenerate

endmodule

// File: rtl/omp_frame_packer.sv
// Packs 24 signed 16-bit residual samples into the 384-bit OPBOMP input
// vector and holds it with frame_valid until the detector takes it.
`timescale 1ns/1ps
module omp_frame_packer
  import omp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  omp_frame_packer_if.slave  bus
);

  logic [0:0]           state_q,       state_d;
  logic [CNT_W-1:0]     cnt_q,         cnt_d;
  logic [X_W-1:0]       x_vec_q,       x_vec_d;
  logic [CNT_W-1:0]     frame_len_q,   frame_len_d;
  logic                 short_frame_q, short_frame_d;
  logic                 frame_valid_q, frame_valid_d;

  logic                 take;
  logic                 close;
  logic                 handoff;
  logic [N_SAMPLES-1:0] slot_we;
  logic [N_SAMPLES-1:0] tail_mask;

  assign take    = bus.s_valid && (state_q == ST_FILL);
  assign close   = take && (bus.s_last || (cnt_q == CNT_W'(N_SAMPLES - 1)));
  assign handoff = frame_valid_q && bus.frame_ready;

  omp_slot_decoder u_slot_decoder (
    .slot      (cnt_q),
    .slot_we   (slot_we),
    .tail_mask (tail_mask)
  );

  // Each slot either takes the incoming sample, is zeroed on an early close,
  // or keeps its old contents (stale data is harmless outside frame_valid).
  generate
    for (genvar gi = 0; gi < N_SAMPLES; gi++) begin : g_pack
      localparam int LSB = slot_lsb(gi);
      assign x_vec_d[LSB +: SAMPLE_W] =
          (take && slot_we[gi])    ? bus.s_data :
          (close && tail_mask[gi]) ? '0         :
                                     x_vec_q[LSB +: SAMPLE_W];
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_len_d   = frame_len_q;
    short_frame_d = short_frame_q;
    frame_valid_d = frame_valid_q;

    case (state_q)
      ST_FILL: begin
        frame_valid_d = 1'b0;
        if (take) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (close) begin
            state_d       = ST_HOLD;
            cnt_d         = '0;
            frame_len_d   = cnt_q + CNT_W'(1);
            short_frame_d = (cnt_q != CNT_W'(N_SAMPLES - 1));
          end
        end
      end
      ST_HOLD: begin
        // frame_valid follows entry into HOLD by one cycle, giving the
        // 26-cycle frame period at full input rate.
        frame_valid_d = 1'b1;
        if (handoff) begin
          state_d       = ST_FILL;
          frame_valid_d = 1'b0;
          cnt_d         = '0;
        end
      end
      default: begin
        state_d       = ST_FILL;
        frame_valid_d = 1'b0;
        cnt_d         = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FILL;
      cnt_q         <= '0;
      x_vec_q       <= '0;
      frame_len_q   <= '0;
      short_frame_q <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      x_vec_q       <= x_vec_d;
      frame_len_q   <= frame_len_d;
      short_frame_q <= short_frame_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign bus.s_ready     = (state_q == ST_FILL);
  assign bus.frame_valid = frame_valid_q;
  assign bus.x_vec       = x_vec_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.short_frame = short_frame_q;

endmodule

// File: tb/tb_omp_frame_packer.sv
// Scoreboard bench for omp_frame_packer: stimulus queues expected frames,
// a negedge monitor compares each presented frame and its stability.
`timescale 1ns/1ps
module tb_omp_frame_packer;
  import omp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  omp_frame_packer_if bus ();

  omp_frame_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [X_W-1:0]   x;
    logic [CNT_W-1:0] len;
    logic             sh;
  } frame_t;

  frame_t          exp_q[$];
  logic [15:0]     cur[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              rise_cyc[$];
  int              last_width = 0;
  logic [15:0]     t1_data[24];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [X_W-1:0] act, input logic [X_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Expected frame from the samples sent since the last push; unused slots are zero.
  task automatic push_expect(input logic sh);
    frame_t f;
    f.x = '0;
    for (int k = 0; k < cur.size(); k++)
      f.x[(N_SAMPLES - 1 - k) * SAMPLE_W +: SAMPLE_W] = cur[k];
    f.len = CNT_W'(cur.size());
    f.sh  = sh;
    exp_q.push_back(f);
    cur.delete();
  endtask

  task automatic send(input logic [15:0] d, input logic l, input int gap);
    int t = 0;
    repeat (gap) begin
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_data  = 16'($urandom);
      bus.s_last  = 1'($urandom);
    end
    @(negedge clk);
    while (bus.s_ready !== 1'b1) begin
      bus.s_valid = 1'b0;
      t++;
      if (t > 300) begin
        fail_now("send_wait_s_ready");
        return;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    cur.push_back(d);
    @(posedge clk);
  endtask

  task automatic handoff(input string tag);
    int t = 0;
    @(negedge clk);
    bus.s_valid = 1'b0;
    while (bus.frame_valid !== 1'b1) begin
      t++;
      if (t > 100) begin
        fail_now({tag, "_wait_frame_valid"});
        return;
      end
      @(negedge clk);
    end
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
    chk_s({tag, "_fv_after_handoff"}, 32'(bus.frame_valid), 32'(0));
    chk_s({tag, "_s_ready_after_handoff"}, 32'(bus.s_ready), 32'(1));
  endtask

  task automatic chk_reset(input string tag);
    chk_s({tag, "_s_ready"}, 32'(bus.s_ready), 32'(1));
    chk_s({tag, "_frame_valid"}, 32'(bus.frame_valid), 32'(0));
    chk({tag, "_x_vec"}, bus.x_vec, '0);
    chk_s({tag, "_frame_len"}, 32'(bus.frame_len), 32'(0));
    chk_s({tag, "_short_frame"}, 32'(bus.short_frame), 32'(0));
  endtask

  // Monitor: compare each newly presented frame, then require it to stay put.
  initial begin
    logic           prev_fv;
    logic [X_W-1:0] held_x;
    int             w;
    frame_t         e;
    prev_fv = 1'b0;
    held_x  = '0;
    w       = 0;
    forever begin
      @(negedge clk);
      if (bus.frame_valid === 1'b1 && !prev_fv) begin
        rise_cyc.push_back(cyc);
        held_x = bus.x_vec;
        w      = 1;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_frame");
        end else begin
          e = exp_q.pop_front();
          $display("frame @%0d len=%0d short=%0b x_vec[383:368]=%h x_vec[15:0]=%h",
                   cyc, bus.frame_len, bus.short_frame, bus.x_vec[383:368], bus.x_vec[15:0]);
          chk("frame_x_vec", bus.x_vec, e.x);
          chk_s("frame_len", 32'(bus.frame_len), 32'(e.len));
          chk_s("frame_short", 32'(bus.short_frame), 32'(e.sh));
        end
      end else if (bus.frame_valid === 1'b1 && prev_fv) begin
        w++;
        chk("x_vec_stable", bus.x_vec, held_x);
      end else if (bus.frame_valid !== 1'b1 && prev_fv) begin
        last_width = w;
      end
      prev_fv = (bus.frame_valid === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int t;
    t1_data = '{16'hff77, 16'h0078, 16'h002d, 16'hfffc, 16'h0113, 16'hfe9a,
                16'h7fff, 16'h8000, 16'h0001, 16'hffff, 16'h1234, 16'hedcb,
                16'h00aa, 16'hff55, 16'h0c0c, 16'hf3f3, 16'h0042, 16'hffbd,
                16'h2000, 16'he000, 16'h0777, 16'hf889, 16'hffb4, 16'hffdc};
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.s_last      = 1'b0;
    bus.frame_ready = 1'b0;
    rst             = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    // Full frame, frame_ready low.
    for (int k = 0; k < 24; k++) send(t1_data[k], 1'b0, 0);
    push_expect(1'b0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk_s("t1_fv_first_cycle", 32'(bus.frame_valid), 32'(0));
    chk_s("t1_s_ready_first_cycle", 32'(bus.s_ready), 32'(0));
    @(negedge clk);
    chk_s("t1_fv_rise", 32'(bus.frame_valid), 32'(1));
    chk_s("t1_s_ready_hold", 32'(bus.s_ready), 32'(0));
    chk_s("t1_msb_slot", 32'(bus.x_vec[383:368]), 32'(16'hff77));
    chk_s("t1_lsb_slot", 32'(bus.x_vec[15:0]), 32'(16'hffdc));
    handoff("t1");

    // Second full frame 0001..0018.
    for (int k = 0; k < 24; k++) send(16'(k + 1), 1'b0, 0);
    push_expect(1'b0);
    handoff("t2");

    // Short frame closed by s_last on slot 2.
    send(16'h0103, 1'b0, 0);
    send(16'hfedf, 1'b0, 0);
    send(16'h011d, 1'b1, 0);
    push_expect(1'b1);
    handoff("t3");

    // Random gaps with garbage on idle cycles, then 50 cycles of HOLD.
    for (int k = 0; k < 24; k++) send(16'($urandom), 1'b0, int'($urandom_range(2, 0)));
    push_expect(1'b0);
    repeat (50) begin
      @(negedge clk);
      bus.s_valid = 1'($urandom);
      bus.s_data  = 16'($urandom);
      bus.s_last  = 1'($urandom);
      chk_s("t4_s_ready_hold", 32'(bus.s_ready), 32'(0));
    end
    handoff("t4");

    // Reset after 10 samples, then a clean frame of 0080.
    for (int k = 0; k < 10; k++) send(16'h7000 + 16'(k), 1'b0, 0);
    cur.delete();
    @(negedge clk);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("t5_reset");
    for (int k = 0; k < 24; k++) send(16'h0080, 1'b0, 0);
    push_expect(1'b0);
    handoff("t5");

    // s_last on slot 23 with frame_ready held high: back-to-back frames.
    n0 = rise_cyc.size();
    bus.frame_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 24; k++) send(16'h0a00 + 16'(f * 32 + k), k == 23, 0);
      push_expect(1'b0);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    t = 0;
    while ((rise_cyc.size() < n0 + 2 || bus.frame_valid === 1'b1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    bus.frame_ready = 1'b0;
    if (rise_cyc.size() < n0 + 2) begin
      fail_now("t6_wait_two_frames");
    end else begin
      chk_s("t6_frame_spacing", 32'(rise_cyc[n0 + 1] - rise_cyc[n0]), 32'(26));
      chk_s("t6_fv_pulse_width", 32'(last_width), 32'(1));
    end

    chk_s("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
